uart_rx_deser_param: RTL and testbench

//  Parametrised UART RX deserializer: collects centre-sampled bits into a parallel word of run-time length
//  (5..DATA_W), LSB- or MSB-first, with optional even/odd parity and stop-bit checking.

---
 rtl/uart_rx_deser_param_pkg.sv | 34 +++
 rtl/uart_rx_deser_param_par_chk.sv | 46 ++++
 rtl/uart_rx_deser_param.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_deser_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deser_param_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_param_pkg
//
// Shared definitions for the UART RX deserializer:
//   - state_e    : deserializer FSM states (IDLE / DATA / PARITY / STOP)
//   - MIN_LEN    : shortest legal data word (bits per frame)
//   - MAX_DATA_W : widest data word the deserializer may be built for
//   - clamp_len  : folds a requested word length into [MIN_LEN, max_len]
// -----------------------------------------------------------------------------
package uart_rx_deser_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    localparam int MIN_LEN    = 5;
    localparam int MAX_DATA_W = 9;

    // Out-of-range requests are clamped rather than rejected, so a bad
    // configuration still produces a deterministic frame length.
    function automatic int clamp_len(input int raw, input int max_len);
        if (raw < MIN_LEN) begin
            return MIN_LEN;
        end
        if (raw > max_len) begin
            return max_len;
        end
        return raw;
    endfunction

endpackage : uart_rx_deser_param_pkg

// File: rtl/uart_rx_deser_param_par_chk.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_param_par_chk
//
// Running parity accumulator for one UART frame. The accumulator XORs every
// data bit as it is collected; the mismatch output compares the received
// parity bit against the expected one for even or odd parity.
//
// Ports
//   clk        in  system clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   clr_i      in  clear the accumulator (new frame or abort)
//   acc_en_i   in  fold bit_i into the accumulator this cycle
//   bit_i      in  data bit being collected
//   par_odd_i  in  1: odd parity, 0: even parity
//   par_bit_i  in  received parity bit
//   mismatch_o out 1 when par_bit_i differs from the expected parity bit
// -----------------------------------------------------------------------------
module uart_rx_deser_param_par_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic acc_en_i,
    input  logic bit_i,
    input  logic par_odd_i,
    input  logic par_bit_i,
    output logic mismatch_o
);

    logic acc_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= 1'b0;
        end else if (acc_en_i) begin
            acc_q <= acc_q ^ bit_i;
        end
    end

    // Expected parity bit is the XOR of all data bits, inverted for odd parity.
    assign mismatch_o = par_bit_i ^ (acc_q ^ par_odd_i);

endmodule : uart_rx_deser_param_par_chk

// File: rtl/uart_rx_deser_param.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_param
//
// Parametrised UART RX deserializer. Collects centre-sampled bits into a
// parallel word whose length (MIN_LEN..DATA_W) is chosen per frame, LSB- or
// MSB-first, with optional even/odd parity and stop-bit checking. Frame
// results are reported as one-cycle strobes one clock after the stop-bit
// sample.
//
// Parameters
//   DATA_W  maximum data bits per frame (5..9), width of P_DATA
//   CNT_W   bit counter width, derived from DATA_W (not overridable)
//
// Ports
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-low reset
//   sampled_bit    in   majority-voted bit, valid with sample_stb
//   sample_stb     in   one-cycle pulse at bit centre
//   frame_start    in   one-cycle pulse: start bit confirmed
//   abort          in   discard current frame, return to IDLE
//   cfg_len        in   data bits per frame (clamped), latched at start
//   cfg_msb_first  in   1: first data bit is the word MSB, latched at start
//   cfg_par_en     in   1: parity bit follows data, latched at start
//   cfg_par_odd    in   1: odd parity, 0: even, latched at start
//   P_DATA         out  last completed word, bits >= len are 0
//   data_valid     out  one-cycle pulse: frame completed without error
//   par_err        out  one-cycle pulse: parity mismatch
//   stop_err       out  one-cycle pulse: stop bit sampled 0
//   busy           out  1 whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_deser_param
    import uart_rx_deser_param_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sampled_bit,
    input  logic              sample_stb,
    input  logic              frame_start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              cfg_msb_first,
    input  logic              cfg_par_en,
    input  logic              cfg_par_odd,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stop_err,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   len_q;
    logic               msb_first_q;
    logic               par_en_q;
    logic               par_odd_q;
    logic               par_mis_q;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  p_data_q;
    logic               data_valid_q;
    logic               par_err_q;
    logic               stop_err_q;

    // ------------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]   len_d;
    logic [CNT_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  shift_d;
    logic               last_data_bit;
    logic               start_accept;
    logic               data_take;
    logic               par_clr;
    logic               par_mismatch;

    // Clamped length is only captured on an accepted frame_start, so later
    // cfg_len changes cannot disturb a frame in flight.
    assign len_d = CNT_W'(clamp_len(int'(cfg_len), DATA_W));

    // MSB-first frames fill the word from bit len-1 downwards.
    assign wr_idx = msb_first_q ? (len_q - CNT_W'(1) - bit_cnt_q) : bit_cnt_q;

    assign last_data_bit = (bit_cnt_q == (len_q - CNT_W'(1)));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (wr_idx == CNT_W'(i)) begin
                shift_d[i] = sampled_bit;
            end
        end
    end

    // abort outranks frame_start and sample_stb for the parity accumulator too.
    assign start_accept = (state_q == ST_IDLE) && frame_start && !abort;
    assign data_take    = (state_q == ST_DATA) && sample_stb && !abort;
    assign par_clr      = abort || start_accept;

    uart_rx_deser_param_par_chk u_par_chk (
        .clk        (CLK),
        .rst_n      (RST),
        .clr_i      (par_clr),
        .acc_en_i   (data_take),
        .bit_i      (sampled_bit),
        .par_odd_i  (par_odd_q),
        .par_bit_i  (sampled_bit),
        .mismatch_o (par_mismatch)
    );

    // ------------------------------------------------------------------------
    // FSM, counter, config latch, assembly and registered results
    // ------------------------------------------------------------------------
    // NOTE: the shift register is reset and also cleared at every accepted
    // start; bits at or above the frame length are never written, so they
    // read back as 0 without any masking on the output.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            len_q        <= '0;
            msb_first_q  <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            par_mis_q    <= 1'b0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            // Result strobes are single-cycle pulses by default.
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;

            if (abort) begin
                // Drops the partial word; P_DATA keeps the last good result.
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                par_mis_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // A sample_stb coinciding with frame_start belongs to
                        // the start bit and is deliberately ignored here.
                        if (frame_start) begin
                            state_q     <= ST_DATA;
                            bit_cnt_q   <= '0;
                            len_q       <= len_d;
                            msb_first_q <= cfg_msb_first;
                            par_en_q    <= cfg_par_en;
                            par_odd_q   <= cfg_par_odd;
                            par_mis_q   <= 1'b0;
                            shift_q     <= '0;
                        end
                    end

                    ST_DATA: begin
                        if (sample_stb) begin
                            shift_q <= shift_d;
                            if (last_data_bit) begin
                                bit_cnt_q <= '0;
                                state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    ST_PARITY: begin
                        // Mismatch is held until the stop bit so that all
                        // error reporting happens on the same cycle.
                        if (sample_stb) begin
                            par_mis_q <= par_mismatch;
                            state_q   <= ST_STOP;
                        end
                    end

                    ST_STOP: begin
                        if (sample_stb) begin
                            p_data_q     <= shift_q;
                            stop_err_q   <= !sampled_bit;
                            par_err_q    <= par_mis_q;
                            data_valid_q <= sampled_bit && !par_mis_q;
                            state_q      <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stop_err   = stop_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule : uart_rx_deser_param

// File: tb/tb_uart_rx_deser_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser_param
//
// Self-checking bench for uart_rx_deser_param (DATA_W = 8). A driver turns
// (config, word) pairs into a sampled bit stream; the expected frame result is
// derived from the word itself (masking, $countones parity) and queued. A
// monitor pops the queue whenever the DUT raises a result strobe and also
// checks that P_DATA holds between results.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser_param;

    logic       CLK = 1'b0;
    logic       RST;
    logic       sampled_bit;
    logic       sample_stb;
    logic       frame_start;
    logic       abort;
    logic [3:0] cfg_len;
    logic       cfg_msb_first;
    logic       cfg_par_en;
    logic       cfg_par_odd;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;
    logic       busy;

    uart_rx_deser_param #(.DATA_W(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .sampled_bit   (sampled_bit),
        .sample_stb    (sample_stb),
        .frame_start   (frame_start),
        .abort         (abort),
        .cfg_len       (cfg_len),
        .cfg_msb_first (cfg_msb_first),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_odd   (cfg_par_odd),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .par_err       (par_err),
        .stop_err      (stop_err),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       se;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_pdata = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: pops one expected result per strobe, otherwise P_DATA must hold
    // ------------------------------------------------------------------------
    always @(negedge CLK) begin
        if (!RST) begin
            last_pdata = 8'h00;
        end else if (data_valid || par_err || stop_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: dv=%0b pe=%0b se=%0b, no frame outstanding (cycle %0d)",
                         data_valid, par_err, stop_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("p_data",         32'(P_DATA),     32'(mon_e.data));
                check("data_valid",     32'(data_valid), 32'(!(mon_e.pe || mon_e.se)));
                check("par_err",        32'(par_err),    32'(mon_e.pe));
                check("stop_err",       32'(stop_err),   32'(mon_e.se));
                check("strobe_latency", 32'(cyc),        32'(mon_e.cyc));
                last_pdata = mon_e.data;
            end
        end else begin
            check("p_data_hold", 32'(P_DATA), 32'(last_pdata));
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------------
    task automatic drive_cycle(input logic fs, input logic stb, input logic b, input logic ab);
        @(negedge CLK);
        frame_start = fs;
        sample_stb  = stb;
        sampled_bit = b;
        abort       = ab;
    endtask

    task automatic scramble_cfg();
        cfg_len       = 4'($urandom);
        cfg_msb_first = 1'($urandom);
        cfg_par_en    = 1'($urandom);
        cfg_par_odd   = 1'($urandom);
    endtask

    // Sends one frame. abort_at indexes the bit sequence (data, parity, stop);
    // the abort pulse replaces normal completion at that sample. noisy adds
    // random gaps, stray frame_start pulses, config changes mid-frame and a
    // sample_stb on the start cycle.
    task automatic send_frame(input int len_cfg, input bit msb, input bit pen, input bit podd,
                              input logic [7:0] word, input bit par_flip, input bit stop_bit,
                              input bit noisy, input int abort_at);
        int         eff;
        int         gap;
        logic [7:0] w;
        logic       seq[$];
        exp_t       e;

        eff = (len_cfg < 5) ? 5 : ((len_cfg > 8) ? 8 : len_cfg);
        w   = word & 8'((1 << eff) - 1);
        for (int i = 0; i < eff; i++) begin
            seq.push_back(msb ? w[eff-1-i] : w[i]);
        end
        if (pen) begin
            // Correct bit makes the total count of ones even (or odd).
            seq.push_back(logic'(($countones(w) % 2) == 1) ^ podd ^ par_flip);
        end
        seq.push_back(stop_bit);

        @(negedge CLK);
        frame_start   = 1'b1;
        abort         = 1'b0;
        cfg_len       = 4'(len_cfg);
        cfg_msb_first = msb;
        cfg_par_en    = pen;
        cfg_par_odd   = podd;
        sample_stb    = noisy && ($urandom_range(0, 3) == 0);
        sampled_bit   = 1'($urandom);
        @(posedge CLK);
        #1 check("busy_after_start", 32'(busy), 32'd1);

        for (int j = 0; j < seq.size(); j++) begin
            gap = noisy ? int'($urandom_range(0, 2)) : 0;
            repeat (gap) begin
                drive_cycle(noisy && ($urandom_range(0, 5) == 0), 1'b0, 1'($urandom), 1'b0);
                if (noisy) scramble_cfg();
            end
            if (j == abort_at) begin
                drive_cycle(1'b0, 1'b1, seq[j], 1'b1);
                break;
            end
            drive_cycle(1'b0, 1'b1, seq[j], 1'b0);
            if (j == seq.size() - 1) begin
                e.data = w;
                e.pe   = pen && par_flip;
                e.se   = !stop_bit;
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1 check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        RST           = 1'b0;
        sampled_bit   = 1'b0;
        sample_stb    = 1'b0;
        frame_start   = 1'b0;
        abort         = 1'b0;
        cfg_len       = 4'd8;
        cfg_msb_first = 1'b0;
        cfg_par_en    = 1'b0;
        cfg_par_odd   = 1'b0;

        repeat (3) @(negedge CLK);
        check("reset_p_data",     32'(P_DATA),     32'h0);
        check("reset_data_valid", 32'(data_valid), 32'h0);
        check("reset_par_err",    32'(par_err),    32'h0);
        check("reset_stop_err",   32'(stop_err),   32'h0);
        check("reset_busy",       32'(busy),       32'h0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed frames
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, -1);
        send_frame(7, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, -1);
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 4);
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, -1);
        // Abort on the stop-bit sample: no strobes, P_DATA stays 0x12.
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8);

        // abort together with frame_start in IDLE rejects the frame.
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1 check("abort_rejects_start", 32'(busy), 32'd0);

        // Reset in the middle of a frame clears everything.
        @(negedge CLK);
        frame_start = 1'b1;
        cfg_len     = 4'd8;
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        sample_stb = 1'b0;
        #1;
        check("midreset_p_data",     32'(P_DATA),     32'h0);
        check("midreset_data_valid", 32'(data_valid), 32'h0);
        check("midreset_par_err",    32'(par_err),    32'h0);
        check("midreset_stop_err",   32'(stop_err),   32'h0);
        check("midreset_busy",       32'(busy),       32'h0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;

        // Length clamps (low and high), with config churn mid-frame.
        send_frame(3,  1'b0, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b1, 1'b1, -1);
        send_frame(15, 1'b1, 1'b1, 1'b1, 8'hC6, 1'b0, 1'b1, 1'b1, -1);

        // Randomized frames with idle-time abort pulses (no-ops in IDLE).
        for (int n = 0; n < 150; n++) begin
            send_frame(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                       8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                       1'b1, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1);
            repeat ($urandom_range(0, 3)) begin
                drive_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_deser_param
